// File: rtl/csr_machine_unit_pkg.sv
// rtl/csr_machine_unit_pkg.sv - shared CSR addresses, interrupt codes and register layouts
package csr_machine_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam logic [4:0] IRQ_MSI        = 5'd3;
    localparam logic [4:0] IRQ_MTI        = 5'd7;
    localparam logic [4:0] IRQ_MEI        = 5'd11;
    localparam logic [4:0] IRQ_LOCAL_BASE = 5'd16;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        TVEC_DIRECT   = 2'd0,
        TVEC_VECTORED = 2'd1
    } tvec_mode_e;

    typedef struct packed {
        logic mpie;
        logic mie;
    } mstatus_t;

    typedef struct packed {
        logic [61:0] base;
        tvec_mode_e  mode;
    } mtvec_t;

    // Reserved modes 2 and 3 collapse to direct.
    function automatic mtvec_t mtvec_legalize(input logic [63:0] v);
        mtvec_t t;
        t.base = v[63:2];
        t.mode = (v[1:0] == 2'd1) ? TVEC_VECTORED : TVEC_DIRECT;
        return t;
    endfunction

endpackage

// File: rtl/csr_irq_arbiter.sv
// rtl/csr_irq_arbiter.sv - fixed-priority encoder over enabled pending interrupts
module csr_irq_arbiter
    import csr_machine_unit_pkg::*;
#(
    parameter int NUM_LOCAL = 4,
    localparam int LW = (NUM_LOCAL > 0) ? NUM_LOCAL : 1
) (
    input  logic          meip,
    input  logic          msip,
    input  logic          mtip,
    input  logic [LW-1:0] local_pend,
    output logic          valid,
    output logic [4:0]    code
);

    // Lowest priority assigned first so later assignments override.
    always_comb begin
        valid = 1'b0;
        code  = '0;
        for (int i = 0; i < LW; i++) begin
            if (local_pend[i]) begin
                valid = 1'b1;
                code  = IRQ_LOCAL_BASE + 5'(i);
            end
        end
        if (mtip) begin
            valid = 1'b1;
            code  = IRQ_MTI;
        end
        if (msip) begin
            valid = 1'b1;
            code  = IRQ_MSI;
        end
        if (meip) begin
            valid = 1'b1;
            code  = IRQ_MEI;
        end
    end

endmodule

// File: rtl/csr_machine_unit.sv
// rtl/csr_machine_unit.sv - machine-mode CSR file and trap/mret controller
module csr_machine_unit
    import csr_machine_unit_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          NUM_LOCAL = 4,
    parameter logic [31:0] MISA_VAL  = 32'h40001100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           csr_op,
    input  logic [11:0]          csr_addr,
    input  logic [XLEN-1:0]      csr_wdata,
    output logic [XLEN-1:0]      csr_rdata,
    output logic                 csr_illegal,
    input  logic                 retire,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_cause,
    input  logic [XLEN-1:0]      exc_tval,
    input  logic [XLEN-1:0]      epc,
    input  logic                 irq_allow,
    input  logic                 mret,
    input  logic                 extern_irpt,
    input  logic                 timer_irpt,
    input  logic                 soft_irpt,
    input  logic [NUM_LOCAL-1:0] local_irpt,
    output logic                 trap,
    output logic [XLEN-1:0]      trap_pc,
    output logic                 mret_out,
    output logic [XLEN-1:0]      mepc_out,
    output logic                 irq_pending
);

    localparam int LW = (NUM_LOCAL > 0) ? NUM_LOCAL : 1;
    localparam logic [XLEN-1:0] MIE_MASK =
        XLEN'(64'h888) | (((XLEN'(1) << NUM_LOCAL) - XLEN'(1)) << 16);

    mstatus_t        mst_q;
    mtvec_t          mtvec_q;
    logic [XLEN-1:0] mie_q, mip_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic            cy_inh_q, ir_inh_q;
    logic [63:0]     mcycle_q, minstret_q;
    logic            trap_q, mret_q;
    logic [XLEN-1:0] trap_pc_q;

    csr_op_e         op;
    logic            impl, is_h, is_write, wr_en;
    logic [XLEN-1:0] rd, wval, mip_next, pend, cause_val, tbase, trap_target;
    logic [63:0]     wv64;
    logic            irq_valid, take_exc, take_irq, trap_take;
    logic [4:0]      irq_code, cause_code;

    assign op = csr_op_e'(csr_op);

    always_comb begin
        impl = 1'b1;
        is_h = 1'b0;
        rd   = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                rd[3]     = mst_q.mie;
                rd[7]     = mst_q.mpie;
                rd[12:11] = 2'b11;
            end
            CSR_MISA:     rd = XLEN'(MISA_VAL);
            CSR_MIE:      rd = mie_q;
            CSR_MIP:      rd = mip_q;
            CSR_MTVEC:    rd = XLEN'(mtvec_q);
            CSR_MSCRATCH: rd = mscratch_q;
            CSR_MEPC:     rd = mepc_q;
            CSR_MCAUSE:   rd = mcause_q;
            CSR_MTVAL:    rd = mtval_q;
            CSR_MCOUNTINHIBIT: begin
                rd[0] = cy_inh_q;
                rd[2] = ir_inh_q;
            end
            CSR_MCYCLE:   rd = XLEN'(mcycle_q);
            CSR_MINSTRET: rd = XLEN'(minstret_q);
            CSR_MCYCLEH: begin
                is_h = 1'b1;
                rd   = XLEN'(mcycle_q[63:32]);
            end
            CSR_MINSTRETH: begin
                is_h = 1'b1;
                rd   = XLEN'(minstret_q[63:32]);
            end
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: rd = '0;
            default: impl = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read, so it never traps on read-only space.
    assign is_write    = (op == CSR_RW) || ((op == CSR_RS || op == CSR_RC) && csr_wdata != '0);
    assign csr_illegal = (op != CSR_NONE) &&
                         (!impl || (is_h && XLEN == 64) || (is_write && csr_addr[11:10] == 2'b11));
    assign csr_rdata   = (op != CSR_NONE && !csr_illegal) ? rd : '0;
    assign wr_en       = is_write && !csr_illegal;

    always_comb begin
        case (op)
            CSR_RW:  wval = csr_wdata;
            CSR_RS:  wval = rd | csr_wdata;
            CSR_RC:  wval = rd & ~csr_wdata;
            default: wval = rd;
        endcase
    end
    assign wv64 = 64'(wval);

    always_comb begin
        mip_next          = '0;
        mip_next[IRQ_MEI] = extern_irpt;
        mip_next[IRQ_MTI] = timer_irpt;
        mip_next[IRQ_MSI] = soft_irpt;
        for (int i = 0; i < NUM_LOCAL; i++) mip_next[16+i] = local_irpt[i];
    end

    assign pend        = mip_q & mie_q;
    assign irq_pending = |pend;

    csr_irq_arbiter #(.NUM_LOCAL(NUM_LOCAL)) u_arb (
        .meip       (pend[IRQ_MEI]),
        .msip       (pend[IRQ_MSI]),
        .mtip       (pend[IRQ_MTI]),
        .local_pend (pend[16 +: LW]),
        .valid      (irq_valid),
        .code       (irq_code)
    );

    assign take_exc   = exc_valid;
    assign take_irq   = !exc_valid && irq_valid && mst_q.mie && irq_allow;
    assign trap_take  = take_exc || take_irq;
    assign cause_code = take_exc ? exc_cause : irq_code;
    assign tbase      = XLEN'({mtvec_q.base, 2'b00});

    always_comb begin
        cause_val         = XLEN'(cause_code);
        cause_val[XLEN-1] = take_irq;
        trap_target       = tbase;
        if (take_irq && mtvec_q.mode == TVEC_VECTORED)
            trap_target = tbase + (XLEN'(cause_code) << 2);
    end

    // Order inside the else-branch matters: increment, then CSR write, then trap/mret override.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mst_q      <= '0;
            mtvec_q    <= '0;
            mie_q      <= '0;
            mip_q      <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            cy_inh_q   <= 1'b0;
            ir_inh_q   <= 1'b0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            trap_q     <= 1'b0;
            mret_q     <= 1'b0;
            trap_pc_q  <= '0;
        end else begin
            mip_q  <= mip_next;
            trap_q <= trap_take;
            mret_q <= mret && !trap_take;
            if (trap_take) trap_pc_q <= trap_target;
            if (!cy_inh_q) mcycle_q <= mcycle_q + 64'd1;
            if (retire && !ir_inh_q) minstret_q <= minstret_q + 64'd1;

            if (wr_en) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mst_q.mie  <= wval[3];
                        mst_q.mpie <= wval[7];
                    end
                    CSR_MIE:      mie_q      <= wval & MIE_MASK;
                    CSR_MTVEC:    mtvec_q    <= mtvec_legalize(wv64);
                    CSR_MSCRATCH: mscratch_q <= wval;
                    CSR_MEPC:     mepc_q     <= {wval[XLEN-1:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= wval;
                    CSR_MTVAL:    mtval_q    <= wval;
                    CSR_MCOUNTINHIBIT: begin
                        cy_inh_q <= wval[0];
                        ir_inh_q <= wval[2];
                    end
                    CSR_MCYCLE:    mcycle_q   <= (XLEN == 64) ? wv64 : {mcycle_q[63:32], wv64[31:0]};
                    CSR_MINSTRET:  minstret_q <= (XLEN == 64) ? wv64 : {minstret_q[63:32], wv64[31:0]};
                    CSR_MCYCLEH:   mcycle_q   <= {wv64[31:0], mcycle_q[31:0]};
                    CSR_MINSTRETH: minstret_q <= {wv64[31:0], minstret_q[31:0]};
                    default: ;
                endcase
            end

            if (trap_take) begin
                mepc_q     <= {epc[XLEN-1:2], 2'b00};
                mcause_q   <= cause_val;
                mtval_q    <= take_exc ? exc_tval : '0;
                mst_q.mpie <= mst_q.mie;
                mst_q.mie  <= 1'b0;
            end else if (mret) begin
                mst_q.mie  <= mst_q.mpie;
                mst_q.mpie <= 1'b1;
            end
        end
    end

    assign trap     = trap_q;
    assign trap_pc  = trap_pc_q;
    assign mret_out = mret_q;
    assign mepc_out = mepc_q;

endmodule

// File: tb/tb_csr_machine_unit.sv
// tb/tb_csr_machine_unit.sv - directed self-checking bench for csr_machine_unit
module tb_csr_machine_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  csr_op = 2'd0;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] csr_wdata = 32'd0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        retire = 1'b0, exc_valid = 1'b0, irq_allow = 1'b0, mret = 1'b0;
    logic [4:0]  exc_cause = 5'd0;
    logic [31:0] exc_tval = 32'd0, epc = 32'd0;
    logic        extern_irpt = 1'b0, timer_irpt = 1'b0, soft_irpt = 1'b0;
    logic [3:0]  local_irpt = 4'd0;
    logic        trap, mret_out, irq_pending;
    logic [31:0] trap_pc, mepc_out;

    logic [1:0]  op64 = 2'd0;
    logic [11:0] addr64 = 12'd0;
    logic [63:0] wdata64 = 64'd0;
    logic [63:0] rdata64, trap_pc64, mepc64;
    logic        illegal64, trap64, mret64, irqp64;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csr_machine_unit dut (
        .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .retire(retire),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .epc(epc),
        .irq_allow(irq_allow), .mret(mret), .extern_irpt(extern_irpt),
        .timer_irpt(timer_irpt), .soft_irpt(soft_irpt), .local_irpt(local_irpt),
        .trap(trap), .trap_pc(trap_pc), .mret_out(mret_out), .mepc_out(mepc_out),
        .irq_pending(irq_pending)
    );

    csr_machine_unit #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .csr_op(op64), .csr_addr(addr64), .csr_wdata(wdata64),
        .csr_rdata(rdata64), .csr_illegal(illegal64), .retire(1'b0),
        .exc_valid(1'b0), .exc_cause(5'd0), .exc_tval(64'd0), .epc(64'd0),
        .irq_allow(1'b0), .mret(1'b0), .extern_irpt(1'b0),
        .timer_irpt(1'b0), .soft_irpt(1'b0), .local_irpt(4'd0),
        .trap(trap64), .trap_pc(trap_pc64), .mret_out(mret64), .mepc_out(mepc64),
        .irq_pending(irqp64)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] v);
        csr_op = 2'd2; csr_addr = a; csr_wdata = 32'd0;
        #1;
        v = csr_rdata;
        csr_op = 2'd0;
    endtask

    task automatic csr_do(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
        csr_op = o; csr_addr = a; csr_wdata = d;
        tick();
        csr_op = 2'd0; csr_wdata = 32'd0;
    endtask

    task automatic wait_trap(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (trap) seen = 1'b1;
        end
        check_eq(tag, seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        tick(); tick();
        check_eq("rst_trap", trap, 0);
        check_eq("rst_mret", mret_out, 0);
        check_eq("rst_mepc", mepc_out, 0);
        check_eq("rst_irqp", irq_pending, 0);
        rst = 1'b1;
        tick();
        csr_read(12'h301, v); check_eq("misa", v, 32'h40001100);
        csr_read(12'h300, v); check_eq("mstatus_rst", v, 32'h1800);
        csr_read(12'h305, v); check_eq("mtvec_rst", v, 0);

        // counters: inhibit, write priority, retire counting
        csr_do(2'd2, 12'h320, 32'd1);
        csr_read(12'h320, v); check_eq("inhibit_set", v, 1);
        csr_do(2'd1, 12'hB00, 32'd100);
        retire = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        retire = 1'b0;
        csr_read(12'hB00, v); check_eq("mcycle_frozen", v, 100);
        csr_read(12'hB02, v); check_eq("minstret_10", v, 10);
        csr_read(12'hB80, v); check_eq("mcycleh", v, 0);
        csr_do(2'd3, 12'h320, 32'd1);
        csr_do(2'd1, 12'hB00, 32'd5);
        csr_read(12'hB00, v); check_eq("mcycle_wr5", v, 5);
        tick();
        csr_read(12'hB00, v); check_eq("mcycle_6", v, 6);

        // read-only and unimplemented space
        csr_op = 2'd1; csr_addr = 12'hF11; csr_wdata = 32'h55; #1;
        check_eq("ro_wr_illegal", csr_illegal, 1);
        check_eq("ro_wr_rdata", csr_rdata, 0);
        tick(); csr_op = 2'd0;
        csr_op = 2'd2; csr_addr = 12'hF11; csr_wdata = 32'd0; #1;
        check_eq("ro_rs0_legal", csr_illegal, 0);
        check_eq("ro_rs0_rdata", csr_rdata, 0);
        csr_addr = 12'h7C0; #1;
        check_eq("unimpl_illegal", csr_illegal, 1);
        csr_op = 2'd0;
        csr_do(2'd1, 12'h301, 32'd0);
        csr_read(12'h301, v); check_eq("misa_unchanged", v, 32'h40001100);

        // vectored timer interrupt
        csr_do(2'd1, 12'h305, 32'h1001);
        csr_do(2'd1, 12'h304, 32'h80);
        csr_do(2'd2, 12'h300, 32'h8);
        timer_irpt = 1'b1; irq_allow = 1'b1; epc = 32'h200;
        wait_trap("vec_trap");
        check_eq("vec_trap_pc", trap_pc, 32'h101C);
        check_eq("vec_mepc", mepc_out, 32'h200);
        csr_read(12'h342, v); check_eq("vec_mcause", v, 32'h80000007);
        csr_read(12'h300, v); check_eq("vec_mstatus", v, 32'h1880);
        csr_read(12'h343, v); check_eq("vec_mtval", v, 0);
        check_eq("irqp_mie_off", irq_pending, 1);
        tick();
        check_eq("vec_no_retrap", trap, 0);
        timer_irpt = 1'b0;
        tick(); tick();
        check_eq("irqp_clear", irq_pending, 0);

        // interrupt priority
        csr_do(2'd1, 12'h304, 32'h80888);
        csr_read(12'h304, v); check_eq("mie_all", v, 32'h80888);
        soft_irpt = 1'b1; timer_irpt = 1'b1; extern_irpt = 1'b1; local_irpt = 4'b1000;
        tick();
        csr_do(2'd2, 12'h300, 32'h8);
        wait_trap("prio_mei_trap");
        check_eq("prio_mei_pc", trap_pc, 32'h102C);
        csr_read(12'h342, v); check_eq("prio_mei", v, 32'h8000000B);
        extern_irpt = 1'b0;
        tick();
        csr_do(2'd2, 12'h300, 32'h8);
        wait_trap("prio_msi_trap");
        check_eq("prio_msi_pc", trap_pc, 32'h100C);
        csr_read(12'h342, v); check_eq("prio_msi", v, 32'h80000003);
        soft_irpt = 1'b0; timer_irpt = 1'b0;
        tick();
        csr_do(2'd2, 12'h300, 32'h8);
        wait_trap("prio_loc_trap");
        check_eq("prio_loc_pc", trap_pc, 32'h104C);
        csr_read(12'h342, v); check_eq("prio_local3", v, 32'h80000013);
        local_irpt = 4'd0;
        tick();

        // exception beats pending interrupt, uses base even in vectored mode
        extern_irpt = 1'b1;
        tick();
        csr_do(2'd2, 12'h300, 32'h8);
        exc_valid = 1'b1; exc_cause = 5'd2; exc_tval = 32'hDEAD; epc = 32'h303;
        tick();
        exc_valid = 1'b0; extern_irpt = 1'b0;
        check_eq("exc_trap", trap, 1);
        check_eq("exc_trap_pc", trap_pc, 32'h1000);
        check_eq("exc_mepc", mepc_out, 32'h300);
        csr_read(12'h342, v); check_eq("exc_mcause", v, 2);
        csr_read(12'h343, v); check_eq("exc_mtval", v, 32'hDEAD);

        // mret, then mret suppressed by a same-cycle exception
        irq_allow = 1'b0;
        tick();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check_eq("mret_pulse", mret_out, 1);
        csr_read(12'h300, v); check_eq("mret_mstatus", v, 32'h1888);
        tick();
        check_eq("mret_end", mret_out, 0);
        csr_do(2'd3, 12'h300, 32'h8);
        mret = 1'b1; exc_valid = 1'b1; exc_cause = 5'd3; exc_tval = 32'd0;
        tick();
        mret = 1'b0; exc_valid = 1'b0;
        check_eq("sup_mret", mret_out, 0);
        check_eq("sup_trap", trap, 1);
        csr_read(12'h300, v); check_eq("sup_mstatus", v, 32'h1800);
        csr_read(12'h342, v); check_eq("sup_mcause", v, 3);

        // XLEN=64 instance
        op64 = 2'd2; addr64 = 12'hB80; wdata64 = 64'd0; #1;
        check_eq("x64_h_illegal", illegal64, 1);
        check_eq("x64_h_rdata", rdata64, 0);
        op64 = 2'd1; addr64 = 12'hB00; wdata64 = 64'h1_FFFF_FFFF;
        tick();
        op64 = 2'd2; wdata64 = 64'd0; #1;
        check_eq("x64_mcycle_wr", rdata64, 64'h1_FFFF_FFFF);
        check_eq("x64_mcycle_legal", illegal64, 0);
        op64 = 2'd0;
        tick();
        op64 = 2'd2; #1;
        check_eq("x64_mcycle_carry", rdata64, 64'h2_0000_0000);
        op64 = 2'd0;

        // reset mid-operation aborts the pending trap pulse
        exc_valid = 1'b1; exc_cause = 5'd5; epc = 32'h444; rst = 1'b0;
        tick();
        exc_valid = 1'b0;
        check_eq("rst2_trap", trap, 0);
        check_eq("rst2_mepc", mepc_out, 0);
        rst = 1'b1;
        csr_read(12'h300, v); check_eq("rst2_mstatus", v, 32'h1800);
        csr_read(12'h305, v); check_eq("rst2_mtvec", v, 0);
        csr_read(12'hB00, v); check_eq("rst2_mcycle", v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
